// File: rtl/memory_access.sv
// MEM stage of the 5-stage MIPS pipeline: data RAM load/store with optional wait states,
// branch resolution, MEM forwarding and the MEM/WB pipeline register.
module memory_access #(
  parameter int len         = 32,
  parameter int NB          = $clog2(len),
  parameter int len_mem_bus = 9,
  parameter int len_wb_bus  = 2,
  parameter int ram_depth   = 256,
  parameter int mem_latency = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [len-1:0]        in_pc_branch,
  input  logic [len-1:0]        in_alu,
  input  logic                  in_zero_flag,
  input  logic [len-1:0]        in_reg2,
  input  logic [NB-1:0]         in_write_reg,
  input  logic [len_mem_bus-1:0] memory_bus,
  input  logic [len_wb_bus-1:0] writeBack_bus,
  input  logic                  flush,
  output logic                  out_pc_src,
  output logic [len-1:0]        out_pc_branch,
  output logic [len-1:0]        out_mem_forw,
  output logic                  stall,
  output logic [len-1:0]        out_read_data,
  output logic [len-1:0]        out_alu,
  output logic [NB-1:0]         out_write_reg,
  output logic [len_wb_bus-1:0] writeBack_bus_out,
  output logic                  misaligned
);

  localparam int AW = $clog2(ram_depth);
  localparam logic [3:0] LAT    = 4'(mem_latency);
  localparam logic [3:0] LAT_M1 = 4'(mem_latency - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [len-1:0]        read_data_q, read_data_d;
  logic [len-1:0]        alu_q, alu_d;
  logic [NB-1:0]         write_reg_q, write_reg_d;
  logic [len_wb_bus-1:0] wb_q, wb_d;
  logic                  mis_q, mis_d;

  logic [len-1:0] ram_q [ram_depth];

  logic           mem_write, mem_read, is_write, is_read, access;
  logic [1:0]     size;
  logic           load_unsigned, mis_acc;
  logic [AW-1:0]  word_idx;
  logic [len-1:0] ram_word, wdata, load_val;
  logic [7:0]     byte_sel;
  logic [15:0]    half_sel;
  logic           stall_c, complete, load_entry, we;

  logic unused_bits;
  assign unused_bits = ^{memory_bus[len_mem_bus-1:7], in_alu[len-1:AW+2]};

  assign mem_write     = memory_bus[0];
  assign mem_read      = memory_bus[1];
  assign size          = memory_bus[5:4];
  assign load_unsigned = memory_bus[6];
  assign is_write      = mem_write;
  assign is_read       = mem_read & ~mem_write;
  assign access        = mem_read | mem_write;
  assign word_idx      = in_alu[AW+1:2];
  assign ram_word      = ram_q[word_idx];

  assign mis_acc = access & (((size == 2'b01) & in_alu[0]) |
                             (size[1] & (in_alu[1:0] != 2'b00)));

  assign out_pc_branch = in_pc_branch;
  assign out_mem_forw  = in_alu;
  assign stall         = stall_c & reset;
  assign out_pc_src    = reset & ~stall &
                         ((memory_bus[2] & in_zero_flag) | (memory_bus[3] & ~in_zero_flag));

  // Lane selection and extension, little-endian
  always_comb begin
    byte_sel = ram_word[8*in_alu[1:0] +: 8];
    half_sel = in_alu[1] ? ram_word[31:16] : ram_word[15:0];
    load_val = ram_word;
    wdata    = ram_word;
    case (size)
      2'b00: begin
        load_val = load_unsigned ? {{(len-8){1'b0}}, byte_sel} : {{(len-8){byte_sel[7]}}, byte_sel};
        wdata[8*in_alu[1:0] +: 8] = in_reg2[7:0];
      end
      2'b01: begin
        load_val = load_unsigned ? {{(len-16){1'b0}}, half_sel} : {{(len-16){half_sel[15]}}, half_sel};
        wdata[16*in_alu[1] +: 16] = in_reg2[15:0];
      end
      default: begin
        load_val = ram_word;
        wdata    = in_reg2;
      end
    endcase
  end

  // Wait-state sequencing: decides when the access completes and when MEM/WB takes a bubble
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_c    = 1'b0;
    complete   = 1'b0;
    load_entry = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && access && LAT != 4'd0) begin
          stall_c = 1'b1;
          state_d = WAIT;
          cnt_d   = LAT_M1;
        end else if (!flush) begin
          load_entry = 1'b1;
          complete   = access;
        end
      end
      default: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          load_entry = 1'b1;
          complete   = access;
          state_d    = IDLE;
        end
      end
    endcase

    we          = complete & is_write & ~mis_acc & reset;
    read_data_d = (complete && is_read && !mis_acc) ? load_val : '0;
    alu_d       = load_entry ? in_alu : '0;
    write_reg_d = load_entry ? in_write_reg : '0;
    wb_d        = load_entry ? writeBack_bus : '0;
    mis_d       = load_entry & mis_acc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      read_data_q <= '0;
      alu_q       <= '0;
      write_reg_q <= '0;
      wb_q        <= '0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
      alu_q       <= alu_d;
      write_reg_q <= write_reg_d;
      wb_q        <= wb_d;
      mis_q       <= mis_d;
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (we) ram_q[word_idx] <= wdata;
  end

  assign out_read_data     = read_data_q;
  assign out_alu           = alu_q;
  assign out_write_reg     = write_reg_q;
  assign writeBack_bus_out = wb_q;
  assign misaligned        = mis_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: one instance with no wait states, one with three.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_pc_branch = 32'h0000_0400;
  logic [31:0] in_alu = '0;
  logic        in_zero_flag = 1'b0;
  logic [31:0] in_reg2 = '0;
  logic [4:0]  in_write_reg = 5'd7;
  logic [8:0]  memory_bus = '0;
  logic [1:0]  writeBack_bus = '0;
  logic        flush = 1'b0;

  logic        pc_src0, stall0, mis0, pc_src3, stall3, mis3;
  logic [31:0] pcb0, forw0, rd0, alu0, pcb3, forw3, rd3, alu3;
  logic [4:0]  wreg0, wreg3;
  logic [1:0]  wb0, wb3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  memory_access #(.mem_latency(0)) dut0 (
    .clk(clk), .reset(reset), .in_pc_branch(in_pc_branch), .in_alu(in_alu),
    .in_zero_flag(in_zero_flag), .in_reg2(in_reg2), .in_write_reg(in_write_reg),
    .memory_bus(memory_bus), .writeBack_bus(writeBack_bus), .flush(flush),
    .out_pc_src(pc_src0), .out_pc_branch(pcb0), .out_mem_forw(forw0), .stall(stall0),
    .out_read_data(rd0), .out_alu(alu0), .out_write_reg(wreg0),
    .writeBack_bus_out(wb0), .misaligned(mis0));

  memory_access #(.mem_latency(3)) dut3 (
    .clk(clk), .reset(reset), .in_pc_branch(in_pc_branch), .in_alu(in_alu),
    .in_zero_flag(in_zero_flag), .in_reg2(in_reg2), .in_write_reg(in_write_reg),
    .memory_bus(memory_bus), .writeBack_bus(writeBack_bus), .flush(flush),
    .out_pc_src(pc_src3), .out_pc_branch(pcb3), .out_mem_forw(forw3), .stall(stall3),
    .out_read_data(rd3), .out_alu(alu3), .out_write_reg(wreg3),
    .writeBack_bus_out(wb3), .misaligned(mis3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input logic wr, input logic rd, input logic beq, input logic bne,
                      input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                      input logic [31:0] data, input logic [1:0] wb);
    memory_bus    = {2'b00, uns, sz, bne, beq, rd, wr};
    in_alu        = addr;
    in_reg2       = data;
    writeBack_bus = wb;
  endtask

  task automatic idle();
    setv(0, 0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 2'b00);
  endtask

  initial begin
    // Reset state, with a taken-branch pattern on the inputs
    in_zero_flag = 1'b1;
    setv(0, 0, 1, 0, 2'b00, 0, 32'h0, 32'h0, 2'b00);
    #1;
    chk("rst_pc_src", 32'(pc_src0), 32'd0);
    chk("rst_stall", 32'(stall0), 32'd0);
    chk("rst_read", rd0, 32'h0);
    chk("rst_wb", 32'(wb3), 32'd0);
    step();
    idle();
    in_zero_flag = 1'b0;
    reset = 1'b1;

    // No wait states: word store then load
    setv(1, 0, 0, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF, 2'b00);
    chk("l0_store_stall", 32'(stall0), 32'd0);
    step();
    chk("l0_store_rd0", rd0, 32'h0);
    setv(0, 1, 0, 0, 2'b10, 0, 32'h10, 32'h0, 2'b11);
    chk("l0_load_stall", 32'(stall0), 32'd0);
    step();
    chk("l0_load_word", rd0, 32'hDEADBEEF);
    chk("l0_load_wb", 32'(wb0), 32'd3);
    chk("l0_load_wreg", 32'(wreg0), 32'd7);
    chk("l0_load_alu", alu0, 32'h10);

    // Byte merge and extension
    setv(1, 0, 0, 0, 2'b10, 0, 32'h20, 32'h11223344, 2'b00);
    step();
    setv(1, 0, 0, 0, 2'b00, 0, 32'h21, 32'hFFFFFF80, 2'b00);
    step();
    setv(0, 1, 0, 0, 2'b00, 0, 32'h21, 32'h0, 2'b11);
    step();
    chk("byte_signed", rd0, 32'hFFFFFF80);
    setv(0, 1, 0, 0, 2'b00, 1, 32'h21, 32'h0, 2'b11);
    step();
    chk("byte_unsigned", rd0, 32'h00000080);
    setv(0, 1, 0, 0, 2'b10, 1, 32'h20, 32'h0, 2'b11);
    step();
    chk("word_merged", rd0, 32'h11228044);
    setv(0, 1, 0, 0, 2'b01, 0, 32'h20, 32'h0, 2'b11);
    step();
    chk("half_lo_signed", rd0, 32'hFFFF8044);
    setv(0, 1, 0, 0, 2'b01, 0, 32'h22, 32'h0, 2'b11);
    step();
    chk("half_hi_signed", rd0, 32'h00001122);

    // Branch resolution and pass-through outputs
    in_zero_flag = 1'b1;
    setv(0, 0, 1, 0, 2'b00, 0, 32'h1234, 32'h0, 2'b00);
    #1;
    chk("beq_taken", 32'(pc_src0), 32'd1);
    chk("pc_branch", pcb0, 32'h0000_0400);
    chk("mem_forw", forw0, 32'h1234);
    setv(0, 0, 0, 1, 2'b00, 0, 32'h0, 32'h0, 2'b00);
    #1;
    chk("bne_zero", 32'(pc_src0), 32'd0);
    in_zero_flag = 1'b0;
    #1;
    chk("bne_nonzero", 32'(pc_src0), 32'd1);

    // Misaligned accesses
    setv(0, 1, 0, 0, 2'b10, 0, 32'h12, 32'h0, 2'b11);
    step();
    chk("mis_word_flag", 32'(mis0), 32'd1);
    chk("mis_word_data", rd0, 32'h0);
    setv(1, 0, 0, 0, 2'b01, 0, 32'h13, 32'h0000AAAA, 2'b00);
    step();
    chk("mis_half_flag", 32'(mis0), 32'd1);
    setv(0, 1, 0, 0, 2'b10, 0, 32'h10, 32'h0, 2'b11);
    step();
    chk("mis_ram_kept", rd0, 32'hDEADBEEF);
    chk("mis_clear", 32'(mis0), 32'd0);

    idle();
    repeat (5) step();

    // Three wait states: store
    setv(1, 0, 0, 0, 2'b10, 0, 32'h40, 32'hCAFEF00D, 2'b00);
    #1;
    chk("l3_st_stall_c0", 32'(stall3), 32'd1);
    step();
    chk("l3_st_stall_c1", 32'(stall3), 32'd1);
    chk("l3_st_bubble1", 32'(wb3), 32'd0);
    step();
    chk("l3_st_stall_c2", 32'(stall3), 32'd1);
    step();
    chk("l3_st_stall_c3", 32'(stall3), 32'd0);
    chk("l3_st_bubble3", alu3, 32'h0);
    step();
    chk("l3_st_entry_alu", alu3, 32'h40);
    chk("l3_st_entry_rd", rd3, 32'h0);

    // Three wait states: load, with branch suppressed while stalled
    in_zero_flag = 1'b1;
    setv(0, 1, 1, 0, 2'b10, 0, 32'h40, 32'h0, 2'b11);
    #1;
    chk("l3_ld_stall_c0", 32'(stall3), 32'd1);
    chk("l3_br_stalled", 32'(pc_src3), 32'd0);
    step();
    chk("l3_ld_stall_c1", 32'(stall3), 32'd1);
    step();
    chk("l3_ld_stall_c2", 32'(stall3), 32'd1);
    step();
    chk("l3_ld_stall_c3", 32'(stall3), 32'd0);
    chk("l3_br_released", 32'(pc_src3), 32'd1);
    chk("l3_ld_bubble", 32'(wb3), 32'd0);
    step();
    idle();
    in_zero_flag = 1'b0;
    chk("l3_ld_data", rd3, 32'hCAFEF00D);
    chk("l3_ld_wb", 32'(wb3), 32'd3);

    // Flush during WAIT of a store
    setv(1, 0, 0, 0, 2'b10, 0, 32'h40, 32'h12345678, 2'b01);
    step();
    flush = 1'b1;
    #1;
    chk("fl_stall_off", 32'(stall3), 32'd0);
    step();
    flush = 1'b0;
    chk("fl_bubble_wb", 32'(wb3), 32'd0);
    chk("fl_bubble_reg", 32'(wreg3), 32'd0);
    idle();
    #1;
    chk("fl_idle", 32'(stall3), 32'd0);
    setv(0, 1, 0, 0, 2'b10, 0, 32'h40, 32'h0, 2'b11);
    repeat (4) step();
    idle();
    chk("fl_no_write", rd3, 32'hCAFEF00D);

    // Reset during WAIT of a store
    setv(1, 0, 0, 0, 2'b10, 0, 32'h40, 32'h55555555, 2'b01);
    step();
    chk("rw_stall_pre", 32'(stall3), 32'd1);
    chk("rw_wb0_pre", 32'(wb0), 32'd1);
    reset = 1'b0;
    #1;
    chk("rw_stall", 32'(stall3), 32'd0);
    chk("rw_wb0", 32'(wb0), 32'd0);
    chk("rw_alu0", alu0, 32'h0);
    step();
    idle();
    reset = 1'b1;
    setv(0, 1, 0, 0, 2'b10, 0, 32'h40, 32'h0, 2'b11);
    repeat (4) step();
    idle();
    chk("rw_no_write", rd3, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
